// File: rtl/alu_issue_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_pkg
// Shared definitions for the ALU issue stage and the ALU it feeds.
//   DATA_W      : operand/result width
//   REG_ADDR_W  : register specifier width (r0 is hard-wired to zero)
//   ALU_*       : aluOp encodings shared with the ALU
//   REG_ZERO    : specifier of the zero register
//   fwd_hit()   : true when a bypass source supplies a given source register
// -----------------------------------------------------------------------------
package alu_issue_stage_pkg;

  localparam int unsigned DATA_W     = 24;
  localparam int unsigned REG_ADDR_W = 4;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // A bypass never targets r0: a producer "writing" r0 must not override the
  // hard-wired zero.
  function automatic logic fwd_hit(input logic                  src_valid,
                                   input logic [REG_ADDR_W-1:0] src_rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return src_valid && (src_rd == rs) && (rs != REG_ZERO);
  endfunction

endpackage

// File: rtl/alu_issue_stage_operand_fwd_mux.sv
// -----------------------------------------------------------------------------
// operand_fwd_mux
// Combinational operand select for one source register.
//   rs_i        : source register specifier
//   rf_data_i   : register-file read data for rs_i
//   ex_*_i      : EX/MEM bypass (valid, destination, data)
//   wb_*_i      : MEM/WB bypass (valid, destination, data)
//   data_o      : resolved operand
// Priority: r0 -> 0, then EX/MEM, then MEM/WB, then register file.
// Build option ALU_ISSUE_FWD_EN: when undefined the bypass inputs are ignored
// and only the r0 zeroing is applied.
// -----------------------------------------------------------------------------
module operand_fwd_mux
  import alu_issue_stage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [DATA_W-1:0]     rf_data_i,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [DATA_W-1:0]     ex_data_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic [DATA_W-1:0]     data_o
);

`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    data_o = rf_data_i;
    if (rs_i == REG_ZERO) begin
      data_o = '0;
    end else if (fwd_hit(ex_valid_i, ex_rd_i, rs_i)) begin
      // Younger result wins over the older MEM/WB one.
      data_o = ex_data_i;
    end else if (fwd_hit(wb_valid_i, wb_rd_i, rs_i)) begin
      data_o = wb_data_i;
    end
  end
`else
  // Bypass ports are kept for a uniform interface; decode interlocks instead.
  logic unused_fwd;
  assign unused_fwd = ^{ex_valid_i, ex_rd_i, ex_data_i, wb_valid_i, wb_rd_i, wb_data_i};

  always_comb begin
    data_o = rf_data_i;
    if (rs_i == REG_ZERO) begin
      data_o = '0;
    end
  end
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Execute-entry pipeline register in front of the ALU. Accepts decoded
// instructions over valid/ready, resolves operand bypassing at capture time,
// picks register or immediate for operand 2 and registers the ALU inputs.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid / in_ready        : decode handshake (in_ready = !out_valid || !stall)
//   in_aluOp, in_rs1, in_rs2,
//   in_rs1Data, in_rs2Data,
//   in_imm, in_useImm,
//   in_rd, in_regWrite         : decoded instruction fields
//   exFwd*, wbFwd*             : EX/MEM and MEM/WB result bypasses
//   stall                      : downstream cannot take a new instruction
//   flush                      : kill held and incoming instruction
//   out_valid, aluOp,
//   data1, data2, storeData,
//   out_rd, out_regWrite       : registered ALU-side outputs
//
// Build option ALU_ISSUE_FWD_EN: define to enable operand bypassing;
// otherwise operands come from the register file (r0 still reads zero).
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_aluOp,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [DATA_W-1:0]     in_rs1Data,
  input  logic [DATA_W-1:0]     in_rs2Data,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  in_useImm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_regWrite,
  input  logic                  exFwdValid,
  input  logic [REG_ADDR_W-1:0] exFwdRd,
  input  logic [DATA_W-1:0]     exFwdData,
  input  logic                  wbFwdValid,
  input  logic [REG_ADDR_W-1:0] wbFwdRd,
  input  logic [DATA_W-1:0]     wbFwdData,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [1:0]            aluOp,
  output logic [DATA_W-1:0]     data1,
  output logic [DATA_W-1:0]     data2,
  output logic [DATA_W-1:0]     storeData,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_regWrite
);

  logic [DATA_W-1:0]     rs1_fwd;
  logic [DATA_W-1:0]     rs2_fwd;
  logic [DATA_W-1:0]     op2_sel;
  logic                  accept;

  logic                  valid_q;
  logic [1:0]            aluop_q;
  logic [DATA_W-1:0]     data1_q;
  logic [DATA_W-1:0]     data2_q;
  logic [DATA_W-1:0]     store_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  regwrite_q;

  operand_fwd_mux u_rs1_fwd (
    .rs_i       (in_rs1),
    .rf_data_i  (in_rs1Data),
    .ex_valid_i (exFwdValid),
    .ex_rd_i    (exFwdRd),
    .ex_data_i  (exFwdData),
    .wb_valid_i (wbFwdValid),
    .wb_rd_i    (wbFwdRd),
    .wb_data_i  (wbFwdData),
    .data_o     (rs1_fwd)
  );

  operand_fwd_mux u_rs2_fwd (
    .rs_i       (in_rs2),
    .rf_data_i  (in_rs2Data),
    .ex_valid_i (exFwdValid),
    .ex_rd_i    (exFwdRd),
    .ex_data_i  (exFwdData),
    .wb_valid_i (wbFwdValid),
    .wb_rd_i    (wbFwdRd),
    .wb_data_i  (wbFwdData),
    .data_o     (rs2_fwd)
  );

  assign op2_sel  = in_useImm ? in_imm : rs2_fwd;

  // Ready is independent of in_valid so decode can use it without a loop.
  assign in_ready = !valid_q || !stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      aluop_q    <= ALU_ADD;
      data1_q    <= '0;
      data2_q    <= '0;
      store_q    <= '0;
      rd_q       <= REG_ZERO;
      regwrite_q <= 1'b0;
    end else if (flush) begin
      // Incoming instruction is consumed by the handshake but dropped here.
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      aluop_q    <= in_aluOp;
      data1_q    <= rs1_fwd;
      data2_q    <= op2_sel;
      store_q    <= rs2_fwd;
      rd_q       <= in_rd;
      regwrite_q <= in_regWrite;
    end else if (valid_q && !stall) begin
      // Drain: data registers keep stale values, only the qualifiers clear.
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign aluOp        = aluop_q;
  assign data1        = data1_q;
  assign data2        = data2_q;
  assign storeData    = store_q;
  assign out_rd       = rd_q;
  assign out_regWrite = regwrite_q && valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluOp;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic [23:0] in_rs1Data, in_rs2Data, in_imm;
  logic        in_useImm, in_regWrite;
  logic        exFwdValid, wbFwdValid;
  logic [3:0]  exFwdRd, wbFwdRd;
  logic [23:0] exFwdData, wbFwdData;
  logic        stall, flush;
  logic        out_valid;
  logic [1:0]  aluOp;
  logic [23:0] data1, data2, storeData;
  logic [3:0]  out_rd;
  logic        out_regWrite;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_aluOp     (in_aluOp),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rs1Data   (in_rs1Data),
    .in_rs2Data   (in_rs2Data),
    .in_imm       (in_imm),
    .in_useImm    (in_useImm),
    .in_rd        (in_rd),
    .in_regWrite  (in_regWrite),
    .exFwdValid   (exFwdValid),
    .exFwdRd      (exFwdRd),
    .exFwdData    (exFwdData),
    .wbFwdValid   (wbFwdValid),
    .wbFwdRd      (wbFwdRd),
    .wbFwdData    (wbFwdData),
    .stall        (stall),
    .flush        (flush),
    .out_valid    (out_valid),
    .aluOp        (aluOp),
    .data1        (data1),
    .data2        (data2),
    .storeData    (storeData),
    .out_rd       (out_rd),
    .out_regWrite (out_regWrite)
  );

  // e* = expected with bypassing enabled, n* = expected with it disabled.
  typedef struct {
    logic [1:0]  op;
    logic [3:0]  rs1, rs2;
    logic [23:0] d1, d2, imm;
    logic        ui;
    logic [3:0]  rd;
    logic        rw;
    logic        exv;
    logic [3:0]  exrd;
    logic [23:0] exd;
    logic        wbv;
    logic [3:0]  wbrd;
    logic [23:0] wbd;
    logic [23:0] e1, e2, es, n1, n2, ns;
  } vec_t;

  vec_t vec [8];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_valid    = 1'b1;
    in_aluOp    = v.op;
    in_rs1      = v.rs1;
    in_rs2      = v.rs2;
    in_rs1Data  = v.d1;
    in_rs2Data  = v.d2;
    in_imm      = v.imm;
    in_useImm   = v.ui;
    in_rd       = v.rd;
    in_regWrite = v.rw;
    exFwdValid  = v.exv;
    exFwdRd     = v.exrd;
    exFwdData   = v.exd;
    wbFwdValid  = v.wbv;
    wbFwdRd     = v.wbrd;
    wbFwdData   = v.wbd;
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".aluOp"}, 32'(aluOp), 32'(v.op));
    chk({tag, ".data1"}, 32'(data1), 32'(FwdEn ? v.e1 : v.n1));
    chk({tag, ".data2"}, 32'(data2), 32'(FwdEn ? v.e2 : v.n2));
    chk({tag, ".storeData"}, 32'(storeData), 32'(FwdEn ? v.es : v.ns));
    chk({tag, ".out_rd"}, 32'(out_rd), 32'(v.rd));
    chk({tag, ".out_regWrite"}, 32'(out_regWrite), 32'(v.rw));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".aluOp"}, 32'(aluOp), 32'd0);
    chk({tag, ".data1"}, 32'(data1), 32'd0);
    chk({tag, ".data2"}, 32'(data2), 32'd0);
    chk({tag, ".storeData"}, 32'(storeData), 32'd0);
    chk({tag, ".out_rd"}, 32'(out_rd), 32'd0);
    chk({tag, ".out_regWrite"}, 32'(out_regWrite), 32'd0);
  endtask

  initial begin
    //        op  rs1 rs2 d1        d2        imm       ui  rd  rw
    //        exv exrd exd      wbv wbrd wbd      e1 e2 es / n1 n2 ns
    vec[0] = '{2'd0, 4'd2, 4'd3, 24'h000010, 24'h000005, 24'h0, 1'b0, 4'd1, 1'b1,
               1'b0, 4'd0, 24'h0, 1'b0, 4'd0, 24'h0,
               24'h000010, 24'h000005, 24'h000005, 24'h000010, 24'h000005, 24'h000005};
    vec[1] = '{2'd0, 4'd4, 4'd5, 24'h000111, 24'h000222, 24'h0, 1'b0, 4'd2, 1'b1,
               1'b1, 4'd4, 24'h0000AA, 1'b1, 4'd4, 24'h0000BB,
               24'h0000AA, 24'h000222, 24'h000222, 24'h000111, 24'h000222, 24'h000222};
    vec[2] = '{2'd1, 4'd4, 4'd5, 24'h000111, 24'h000222, 24'h0, 1'b0, 4'd3, 1'b0,
               1'b0, 4'd4, 24'h0000AA, 1'b1, 4'd4, 24'h0000BB,
               24'h0000BB, 24'h000222, 24'h000222, 24'h000111, 24'h000222, 24'h000222};
    vec[3] = '{2'd2, 4'd0, 4'd5, 24'h000333, 24'h000222, 24'h0, 1'b0, 4'd4, 1'b1,
               1'b1, 4'd0, 24'h0000AA, 1'b1, 4'd0, 24'h0000BB,
               24'h000000, 24'h000222, 24'h000222, 24'h000000, 24'h000222, 24'h000222};
    vec[4] = '{2'd1, 4'd1, 4'd6, 24'h000042, 24'h000999, 24'hFFFFFE, 1'b1, 4'd5, 1'b1,
               1'b1, 4'd6, 24'h000007, 1'b0, 4'd0, 24'h0,
               24'h000042, 24'hFFFFFE, 24'h000007, 24'h000042, 24'hFFFFFE, 24'h000999};
    vec[5] = '{2'd2, 4'd8, 4'd7, 24'h000011, 24'h000123, 24'h0, 1'b0, 4'd6, 1'b1,
               1'b1, 4'd8, 24'h0000CC, 1'b1, 4'd7, 24'h000456,
               24'h0000CC, 24'h000456, 24'h000456, 24'h000011, 24'h000123, 24'h000123};
    vec[6] = '{2'd0, 4'd3, 4'd0, 24'h000077, 24'hABCDEF, 24'h0, 1'b0, 4'd7, 1'b1,
               1'b1, 4'd0, 24'h0000EE, 1'b0, 4'd0, 24'h0,
               24'h000077, 24'h000000, 24'h000000, 24'h000077, 24'h000000, 24'h000000};
    vec[7] = '{2'd0, 4'd9, 4'd10, 24'h000055, 24'h000066, 24'h0, 1'b0, 4'd15, 1'b0,
               1'b1, 4'd9, 24'h000001, 1'b1, 4'd10, 24'h000002,
               24'h000001, 24'h000002, 24'h000002, 24'h000055, 24'h000066, 24'h000066};

    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(vec[0]);
    in_valid = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back table vectors, one accept per cycle.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(vec[i]);
      @(posedge clk);
      @(negedge clk);
      chk_vec($sformatf("vec%0d", i), vec[i]);
    end

    // Drain with nothing new offered.
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk("drain.out_regWrite", 32'(out_regWrite), 32'd0);
    chk("drain.in_ready", 32'(in_ready), 32'd1);

    // Stall for 3 cycles with a new instruction waiting.
    drive(vec[0]);
    @(posedge clk);
    @(negedge clk);
    drive(vec[4]);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
      chk_vec($sformatf("stall%0d", c), vec[0]);
      @(posedge clk);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("unstall.in_ready", 32'(in_ready), 32'd1);
    chk_vec("unstall.held", vec[0]);
    @(posedge clk);
    @(negedge clk);
    chk_vec("unstall.next", vec[4]);

    // Flush with a live instruction and a new one offered.
    drive(vec[5]);
    flush = 1'b1;
    #1;
    chk("flush.in_ready_pre", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.out_regWrite", 32'(out_regWrite), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("flush.gone", 32'(out_valid), 32'd0);

    // Flush beats stall.
    drive(vec[1]);
    @(posedge clk);
    @(negedge clk);
    stall = 1'b1;
    flush = 1'b1;
    drive(vec[2]);
    @(posedge clk);
    @(negedge clk);
    chk("flushstall.out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flushstall.in_ready", 32'(in_ready), 32'd1);
    stall = 1'b0;

    // Async reset while stalled.
    drive(vec[4]);
    @(posedge clk);
    @(negedge clk);
    stall = 1'b1;
    drive(vec[5]);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("areset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("areset.in_ready", 32'(in_ready), 32'd1);
    stall = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
